// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle a+b+c_in adder, one CHUNK-bit slice per clock, start/busy/done handshake.
// Optional macro SELF_CHECK_EN adds a full-width reference compare that sets the sticky chk_err flag.
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             chk_err
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d, c_out_q, c_out_d, ovf_q, ovf_d;
    logic [CHUNK:0]   slice;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        slice   = {1'b0, a_q[idx_q*CHUNK +: CHUNK]} + {1'b0, b_q[idx_q*CHUNK +: CHUNK]}
                + (CHUNK+1)'(carry_q);
        case (state_q)
            BUSY: begin
                acc_d[idx_q*CHUNK +: CHUNK] = slice[CHUNK-1:0];
                carry_d = slice[CHUNK];
                idx_d   = idx_q + 1'b1;
                // Results are published only on the last slice so outputs never show partial sums.
                if (idx_q == LAST) begin
                    sum_d   = acc_d;
                    c_out_d = slice[CHUNK];
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
                    state_d = DONE;
                end
            end
            default: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    idx_d   = '0;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy  = state_q == BUSY;
    assign done  = state_q == DONE;
    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

`ifdef SELF_CHECK_EN
    logic             cin_q, cin_d, chk_err_q, chk_err_d, mism;
    logic [WIDTH:0]   ref_sum;

    assign ref_sum = {1'b0, a_q} + {1'b0, b_q} + (WIDTH+1)'(cin_q);

    always_comb begin
        cin_d     = (state_q != BUSY && start) ? c_in : cin_q;
        mism      = (state_q == BUSY) && (idx_q == LAST) && ({slice[CHUNK], acc_d} != ref_sum);
        chk_err_d = chk_err_q | mism;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cin_q     <= 1'b0;
            chk_err_q <= 1'b0;
        end else begin
            cin_q     <= cin_d;
            chk_err_q <= chk_err_d;
`ifndef SYNTHESIS
            if (mism)
                $display("seq_chunk_adder self-check mismatch: a=%h b=%h c_in=%b", a_q, b_q, cin_q);
`endif
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif
endmodule
